// File: rtl/spike_weight_stage.sv
// Weighted spike front end: a divide-by-HEIGHT tick, one accumulator-overflow rate divider per
// channel, and a one-slow-period delay on excitatory channels. All slow logic is tick-enabled.
module spike_weight_stage #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 7,
    parameter logic [WIDTH:0] WEIGHTS [HEIGHT] = '{
        9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260
    }
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [HEIGHT-1:0] pixels_i,
    input  logic              stim_i,
    output logic              tick_o,
    output logic [HEIGHT-1:0] pixels_out_o
);

    localparam int unsigned CntW = $clog2(HEIGHT);
    localparam logic [CntW-1:0] CntLast = CntW'(HEIGHT - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tick;
    logic              ev;
    logic [HEIGHT-1:0] out_d, out_q;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntLast);
    assign ev   = tick & stim_i;

    for (genvar i = 0; i < HEIGHT; i++) begin : g_ch
        localparam logic [WIDTH-1:0] Mag  = WEIGHTS[i][WIDTH-1:0];
        localparam logic             Sign = WEIGHTS[i][WIDTH];

        if (WEIGHTS[i] == '0) begin : g_zero
            logic unused_pix;
            assign unused_pix = pixels_i[i];
            assign out_d[i]   = 1'b0;
        end else begin : g_div
            logic [WIDTH-1:0] acc_q, acc_d;
            logic [WIDTH:0]   sum;
            logic             fire;

            // The carry out of the modulo-2^WIDTH add is the fire; the residue is kept.
            always_comb begin
                sum   = {1'b0, acc_q} + {1'b0, Mag};
                acc_d = acc_q;
                fire  = 1'b0;
                if (ev && pixels_i[i]) begin
                    acc_d = sum[WIDTH-1:0];
                    fire  = sum[WIDTH];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            if (Sign) begin : g_inh
                // ev is already zero off-tick, so this pulse is tick-qualified.
                assign out_d[i] = ev & ~fire;
            end else begin : g_exc
                logic pend_q;

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        pend_q <= 1'b0;
                    end else if (tick) begin
                        pend_q <= fire;
                    end
                end

                assign out_d[i] = tick & pend_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign tick_o       = tick;
    assign pixels_out_o = out_q;

endmodule

// File: tb/tb_spike_weight_stage.sv
// Scoreboard bench for spike_weight_stage: two weight configurations driven in parallel and
// compared cycle by cycle against an arithmetic reference model.
module tb_spike_weight_stage;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HEIGHT = 7;
    localparam logic [WIDTH:0] WA [HEIGHT] = '{
        9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260
    };
    // Channel 4 zero-weight, channel 6 inhibitory with zero magnitude.
    localparam logic [WIDTH:0] WB [HEIGHT] = '{
        9'd255, 9'd255, 9'd60, 9'd260, 9'd0, 9'd260, 9'd256
    };

    typedef struct {
        logic              tick;
        logic [HEIGHT-1:0] out_a;
        logic [HEIGHT-1:0] out_b;
        int                cyc;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [HEIGHT-1:0] pixels_i = '0;
    logic              stim_i = 1'b0;
    logic              tick_a, tick_b;
    logic [HEIGHT-1:0] out_a, out_b;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference model state.
    int                cyc;
    int                acc [2][HEIGHT];
    bit                pend [2][HEIGHT];
    logic [HEIGHT-1:0] exp_out [2];

    always #5 clk_i = ~clk_i;

    spike_weight_stage #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WEIGHTS(WA)) dut_a (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pixels_i    (pixels_i),
        .stim_i      (stim_i),
        .tick_o      (tick_a),
        .pixels_out_o(out_a)
    );

    spike_weight_stage #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WEIGHTS(WB)) dut_b (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pixels_i    (pixels_i),
        .stim_i      (stim_i),
        .tick_o      (tick_b),
        .pixels_out_o(out_b)
    );

    function automatic int weight(input int d, input int ch);
        return (d == 0) ? int'(WA[ch]) : int'(WB[ch]);
    endfunction

    task automatic chk(input string name, input int c, input logic [HEIGHT-1:0] got,
                       input logic [HEIGHT-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b want %b", name, c, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop and compare on the falling edge.
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("tick_a", e.cyc, HEIGHT'(tick_a), HEIGHT'(e.tick));
            chk("tick_b", e.cyc, HEIGHT'(tick_b), HEIGHT'(e.tick));
            chk("out_a", e.cyc, out_a, e.out_a);
            chk("out_b", e.cyc, out_b, e.out_b);
        end
    end

    task automatic model_clear();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            exp_out[d] = '0;
            for (int ch = 0; ch < HEIGHT; ch++) begin
                acc[d][ch]  = 0;
                pend[d][ch] = 1'b0;
            end
        end
    endtask

    // Drive one cycle, record what the DUTs must show during it, then advance the model.
    task automatic step(input logic [HEIGHT-1:0] pix, input logic s);
        exp_t              e;
        bit                tk;
        logic [HEIGHT-1:0] nxt;
        pixels_i = pix;
        stim_i   = s;
        tk       = (cyc % HEIGHT) == (HEIGHT - 1);
        e.tick   = tk;
        e.out_a  = exp_out[0];
        e.out_b  = exp_out[1];
        e.cyc    = cyc;
        sb.push_back(e);
        for (int d = 0; d < 2; d++) begin
            nxt = '0;
            if (tk) begin
                for (int ch = 0; ch < HEIGHT; ch++) begin
                    int w;
                    int m;
                    bit fire;
                    w    = weight(d, ch);
                    m    = w % (1 << WIDTH);
                    fire = 1'b0;
                    if (s && pix[ch]) begin
                        acc[d][ch] = acc[d][ch] + m;
                        fire       = acc[d][ch] >= (1 << WIDTH);
                        acc[d][ch] = acc[d][ch] % (1 << WIDTH);
                    end
                    if (w == 0) begin
                        nxt[ch] = 1'b0;
                    end else if (w >= (1 << WIDTH)) begin
                        nxt[ch] = s && !fire;
                    end else begin
                        nxt[ch]     = pend[d][ch];
                        pend[d][ch] = fire;
                    end
                end
            end
            exp_out[d] = nxt;
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst_ni = 1'b0;
        for (int k = 0; k < n; k++) begin
            e.tick  = 1'b0;
            e.out_a = '0;
            e.out_b = '0;
            e.cyc   = -1;
            sb.push_back(e);
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b1;
        model_clear();
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Idle: ticks only, no outputs.
        for (int k = 0; k < 21; k++) step(HEIGHT'($urandom), 1'b0);

        // stim only off-tick: no accumulation, no outputs.
        for (int k = 0; k < 28; k++) step(HEIGHT'($urandom), ((cyc % HEIGHT) != HEIGHT - 1));

        // Build up state, then reset mid-period.
        for (int k = 0; k < 40; k++) step('1, 1'b1);
        for (int k = 0; k < 3; k++) step('1, 1'b1);
        do_reset(2);

        // Full-rate run: m=60, m=4 and m=255 boundary sequences (events 1..260).
        for (int k = 0; k < 260 * HEIGHT; k++) step('1, 1'b1);

        // Mixed pixel vector.
        for (int k = 0; k < 20 * HEIGHT; k++) step(7'b0101010, 1'b1);

        // Random stimulus.
        for (int k = 0; k < 400; k++) step(HEIGHT'($urandom), 1'($urandom_range(0, 1)));

        @(negedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
